// File: rtl/alu_sched.sv
// alu_sched: round-robin arbiter sharing one ALU between two request channels.
// Optional `ALU_SCHED_STATS_EN adds per-channel and IRQ response counters.
module alu_sched #(
  parameter bit FIXED_PRIO = 1'b0,
  parameter bit RR_INIT    = 1'b0
) (
  input  logic       alu_clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [1:0] req0_op,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [1:0] req1_op,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic       irq_clr,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_data,
  output logic       rsp_irq,
`ifdef ALU_SCHED_STATS_EN
  output logic [15:0] stat_ops0,
  output logic [15:0] stat_ops1,
  output logic [15:0] stat_irq,
`endif
  output logic       alu_enable,
  output logic       alu_enable_a,
  output logic       alu_enable_b,
  output logic [1:0] alu_op_a,
  output logic [1:0] alu_op_b,
  output logic [7:0] alu_in_a,
  output logic [7:0] alu_in_b,
  output logic       alu_irq_clr,
  input  logic [7:0] alu_out,
  input  logic       alu_irq
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESP} state_t;

  state_t     r_state, w_state_nxt;
  logic       r_rr_ptr, r_id, r_irq_pend;
  logic       r_en, r_en_a, r_en_b, r_clr;
  logic [1:0] r_op_a, r_op_b;
  logic [7:0] r_in_a, r_in_b, r_rsp_data;
  logic       r_rsp_valid, r_rsp_id, r_rsp_irq;
  logic       w_grant, w_idle, w_acc, w_rsp_hs;

  always_comb begin
    w_grant = req1_valid;
    if (req0_valid && req1_valid) w_grant = FIXED_PRIO ? 1'b0 : r_rr_ptr;
  end

  assign w_idle     = (r_state == S_IDLE);
  assign req0_ready = w_idle && req0_valid && !w_grant;
  assign req1_ready = w_idle && req1_valid && w_grant;
  assign w_acc      = req0_ready || req1_ready;
  assign w_rsp_hs   = r_rsp_valid && rsp_ready;

  always_ff @(posedge alu_clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_acc) w_state_nxt = S_ISSUE;
      S_ISSUE:   w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = S_RESP;
      S_RESP:    if (w_rsp_hs) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // ALU drive is fully registered so the ALU never sees decode glitches;
  // op/operand registers only change on accept and otherwise hold.
  always_ff @(posedge alu_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= RR_INIT;
      r_id     <= 1'b0;
      r_en     <= 1'b0;
      r_en_a   <= 1'b0;
      r_en_b   <= 1'b0;
      r_clr    <= 1'b0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_in_a   <= '0;
      r_in_b   <= '0;
    end else if (w_acc) begin
      r_id     <= w_grant;
      r_rr_ptr <= ~w_grant;
      r_en     <= 1'b1;
      r_en_a   <= ~w_grant;
      r_en_b   <= w_grant;
      r_clr    <= r_irq_pend | irq_clr;
      if (w_grant) r_op_b <= req1_op;
      else         r_op_a <= req0_op;
      r_in_a   <= w_grant ? req1_a : req0_a;
      r_in_b   <= w_grant ? req1_b : req0_b;
    end else if (r_state == S_ISSUE) begin
      r_en   <= 1'b0;
      r_en_a <= 1'b0;
      r_en_b <= 1'b0;
      r_clr  <= 1'b0;
    end
  end

  // The pending clear is consumed as ISSUE ends; a pulse landing in that same
  // cycle re-arms it for the following issue.
  always_ff @(posedge alu_clk or negedge rst_n) begin
    if (!rst_n)                     r_irq_pend <= 1'b0;
    else if (r_state == S_ISSUE)    r_irq_pend <= irq_clr;
    else                            r_irq_pend <= r_irq_pend | irq_clr;
  end

  always_ff @(posedge alu_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_irq   <= 1'b0;
      r_rsp_data  <= '0;
    end else if (r_state == S_CAPTURE) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= r_id;
      r_rsp_irq   <= alu_irq;
      r_rsp_data  <= alu_out;
    end else if (w_rsp_hs) begin
      r_rsp_valid <= 1'b0;
    end
  end

`ifdef ALU_SCHED_STATS_EN
  logic [15:0] r_ops0, r_ops1, r_irqs;
  always_ff @(posedge alu_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ops0 <= '0;
      r_ops1 <= '0;
      r_irqs <= '0;
    end else if (w_rsp_hs) begin
      if (!r_rsp_id && r_ops0 != 16'hFFFF) r_ops0 <= r_ops0 + 16'd1;
      if (r_rsp_id && r_ops1 != 16'hFFFF)  r_ops1 <= r_ops1 + 16'd1;
      if (r_rsp_irq && r_irqs != 16'hFFFF) r_irqs <= r_irqs + 16'd1;
    end
  end
  assign stat_ops0 = r_ops0;
  assign stat_ops1 = r_ops1;
  assign stat_irq  = r_irqs;
`endif

  assign rsp_valid    = r_rsp_valid;
  assign rsp_id       = r_rsp_id;
  assign rsp_data     = r_rsp_data;
  assign rsp_irq      = r_rsp_irq;
  assign alu_enable   = r_en;
  assign alu_enable_a = r_en_a;
  assign alu_enable_b = r_en_b;
  assign alu_op_a     = r_op_a;
  assign alu_op_b     = r_op_b;
  assign alu_in_a     = r_in_a;
  assign alu_in_b     = r_in_b;
  assign alu_irq_clr  = r_clr;

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched: a round-robin DUT plus a fixed-priority DUT
// on shared stimulus, with a small behavioural ALU behind the round-robin one.
module tb_alu_sched;
  logic       alu_clk, rst_n;
  logic       req0_valid, req1_valid, irq_clr, rsp_ready;
  logic [1:0] req0_op, req1_op;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready, rsp_valid, rsp_id, rsp_irq;
  logic [7:0] rsp_data;
  logic       alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr;
  logic [1:0] alu_op_a, alu_op_b;
  logic [7:0] alu_in_a, alu_in_b;
  logic [7:0] alu_out;
  logic       alu_irq;
  logic       f_req0_ready, f_req1_ready, f_rsp_valid, f_rsp_id, f_rsp_irq;
  logic [7:0] f_rsp_data, f_in_a, f_in_b;
  logic       f_en, f_en_a, f_en_b, f_clr;
  logic [1:0] f_op_a, f_op_b;
`ifdef ALU_SCHED_STATS_EN
  logic [15:0] stat_ops0, stat_ops1, stat_irq, f_s0, f_s1, f_si;
`endif

  int n_chk = 0;
  int n_err = 0;
  logic mon_en = 1'b0;
  logic f_r1_seen = 1'b0;

  alu_sched #(.FIXED_PRIO(1'b0), .RR_INIT(1'b0)) u_dut (
    .alu_clk(alu_clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .irq_clr(irq_clr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_irq(rsp_irq),
`ifdef ALU_SCHED_STATS_EN
    .stat_ops0(stat_ops0), .stat_ops1(stat_ops1), .stat_irq(stat_irq),
`endif
    .alu_enable(alu_enable), .alu_enable_a(alu_enable_a), .alu_enable_b(alu_enable_b),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
    .alu_irq_clr(alu_irq_clr), .alu_out(alu_out), .alu_irq(alu_irq)
  );

  alu_sched #(.FIXED_PRIO(1'b1), .RR_INIT(1'b0)) u_fix (
    .alu_clk(alu_clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .irq_clr(irq_clr), .rsp_valid(f_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(f_rsp_id),
    .rsp_data(f_rsp_data), .rsp_irq(f_rsp_irq),
`ifdef ALU_SCHED_STATS_EN
    .stat_ops0(f_s0), .stat_ops1(f_s1), .stat_irq(f_si),
`endif
    .alu_enable(f_en), .alu_enable_a(f_en_a), .alu_enable_b(f_en_b),
    .alu_op_a(f_op_a), .alu_op_b(f_op_b), .alu_in_a(f_in_a), .alu_in_b(f_in_b),
    .alu_irq_clr(f_clr), .alu_out(alu_out), .alu_irq(alu_irq)
  );

  initial alu_clk = 1'b0;
  always #5 alu_clk = ~alu_clk;

  // A-set: AND OR XOR ADD; B-set: XNOR NAND NOR SUB; irq flags a zero result.
  function automatic logic [7:0] alu_f(input logic bset, input logic [1:0] op, input logic [7:0] x, y);
    case ({bset, op})
      3'b000: return x & y;
      3'b001: return x | y;
      3'b010: return x ^ y;
      3'b011: return x + y;
      3'b100: return ~(x ^ y);
      3'b101: return ~(x & y);
      3'b110: return ~(x | y);
      default: return x - y;
    endcase
  endfunction

  always @(posedge alu_clk) begin
    if (alu_enable) begin
      alu_out <= alu_f(alu_enable_b, alu_enable_b ? alu_op_b : alu_op_a, alu_in_a, alu_in_b);
      alu_irq <= (alu_f(alu_enable_b, alu_enable_b ? alu_op_b : alu_op_a, alu_in_a, alu_in_b) == 8'h00);
    end
  end

  always @(negedge alu_clk) if (mon_en && f_req1_ready) f_r1_seen <= 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic ch, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_d, input logic exp_irq, input logic exp_clr);
    int n;
    @(negedge alu_clk);
    if (ch) begin req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1; end
    else    begin req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1; end
    #1;
    n = 0;
    while (!(ch ? req1_ready : req0_ready) && n < 20) begin
      @(negedge alu_clk); #1; n++;
    end
    chk("accept", ch ? req1_ready : req0_ready, 1);
    @(posedge alu_clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge alu_clk);
    chk("iss_en", alu_enable, 1);
    chk("iss_en_a", alu_enable_a, !ch);
    chk("iss_en_b", alu_enable_b, ch);
    chk("iss_op", ch ? alu_op_b : alu_op_a, op);
    chk("iss_in_a", alu_in_a, a);
    chk("iss_in_b", alu_in_b, b);
    chk("iss_clr", alu_irq_clr, exp_clr);
    @(negedge alu_clk);
    chk("cap_en", alu_enable, 0);
    chk("cap_vld", rsp_valid, 0);
    @(negedge alu_clk);
    chk("rsp_vld", rsp_valid, 1);
    chk("rsp_id", rsp_id, ch);
    chk("rsp_data", rsp_data, exp_d);
    chk("rsp_irq", rsp_irq, exp_irq);
  endtask

  logic       rr_id [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] rr_d  [4] = '{8'h03, 8'h02, 8'h03, 8'h02};

  initial begin
    int n;
    rst_n = 1'b0; irq_clr = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    #1;
    chk("rst_vld", rsp_valid, 0);
    chk("rst_en", alu_enable, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_rdy", {req0_ready, req1_ready}, 0);
    repeat (2) @(negedge alu_clk);
    rst_n = 1'b1;

    run_op(1'b0, 2'b00, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0);
    run_op(1'b1, 2'b00, 8'h0F, 8'h0F, 8'hFF, 1'b0, 1'b0);

    // both channels continuously valid: alternate vs always-ch0
    @(negedge alu_clk);
    req0_op = 2'b11; req0_a = 8'h01; req0_b = 8'h02; req0_valid = 1'b1;
    req1_op = 2'b11; req1_a = 8'h05; req1_b = 8'h03; req1_valid = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!rsp_valid && n < 30) begin @(negedge alu_clk); n++; end
      chk("rr_vld", rsp_valid, 1);
      chk("rr_id", rsp_id, rr_id[i]);
      chk("rr_data", rsp_data, rr_d[i]);
      chk("fx_id", f_rsp_id, 0);
      @(negedge alu_clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    mon_en = 1'b0;
    chk("fx_r1_rdy", f_r1_seen, 0);

    // response back-pressure with an irq_clr pulse while held in RESP
    rsp_ready = 1'b0;
    run_op(1'b0, 2'b10, 8'hAA, 8'h0F, 8'hA5, 1'b0, 1'b0);
    req1_op = 2'b01; req1_a = 8'hFF; req1_b = 8'hFF; req1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge alu_clk);
      chk("stl_vld", rsp_valid, 1);
      chk("stl_data", rsp_data, 8'hA5);
      chk("stl_id", rsp_id, 0);
      chk("stl_rdy", {req0_ready, req1_ready}, 0);
      chk("stl_en", alu_enable, 0);
      irq_clr = (i == 3);
    end
    rsp_ready = 1'b1;
    @(negedge alu_clk); #1;
    chk("rel_idle", req1_ready, 1);
    chk("rel_vld", rsp_valid, 0);
    req1_valid = 1'b0;

    run_op(1'b0, 2'b01, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
    run_op(1'b1, 2'b01, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0);

    // reset landing in CAPTURE discards the operation
    @(negedge alu_clk);
    req0_op = 2'b11; req0_a = 8'h10; req0_b = 8'h20; req0_valid = 1'b1;
    #1;
    chk("mr_acc", req0_ready, 1);
    @(posedge alu_clk); #1;
    req0_valid = 1'b0;
    @(posedge alu_clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mr_in_a", alu_in_a, 0);
    chk("mr_op_a", alu_op_a, 0);
    chk("mr_en", alu_enable, 0);
    chk("mr_vld", rsp_valid, 0);
    repeat (2) @(negedge alu_clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge alu_clk);
      chk("mr_stale", rsp_valid, 0);
    end
`ifdef ALU_SCHED_STATS_EN
    chk("st_rst0", stat_ops0, 0);
    chk("st_rsti", stat_irq, 0);
`endif
    run_op(1'b0, 2'b10, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0);
    @(negedge alu_clk);
    chk("post_vld", rsp_valid, 0);
`ifdef ALU_SCHED_STATS_EN
    chk("st_ops0", stat_ops0, 1);
    chk("st_ops1", stat_ops1, 0);
    chk("st_irq", stat_irq, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
